wb_stream_loader: RTL and testbench
===================================

Name: wb_stream_loader

Overview:
Write-side producer for the weight buffer. It takes a 32-bit weight stream (valid/ready) plus a load command (start line, word count). It packs successive words into the 13 x 32-bit lanes of a 416-bit weight line and drives the weight buffer's external bramctl write port, one byte-enabled lane write per accepted word. It sits between the DMA/AXI weight fetch path and the weight buffer. It reports busy, done and address-overflow status to the NPU controller.

Parameters:
- LANES, 13, 32-bit lanes per weight line.
- LANE_W, 32, bits per lane.
- ADDR_W, 13, weight line address width (8192 lines).
- CNT_W, 17, width of the word-count field (max 8192*13 = 106496).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  load command strobe; accepted only in IDLE.
- i_start_addr  in  ADDR_W  first weight line of the load.
- i_num_words  in  CNT_W  number of 32-bit words to load.
- i_abort  in  1  terminate the current load.
- i_s_data  in  LANE_W  stream word.
- i_s_valid  in  1  stream word valid.
- o_s_ready  out  1  stream word accepted when valid&ready.
- o_wb_bramctl_wdata  out  LANES*LANE_W  write data; accepted word replicated in all lanes.
- o_wb_bramctl_addr  out  ADDR_W  weight line address.
- o_wb_bramctl_be  out  LANES*4  byte enables; only the current lane's 4 bits set.
- o_wb_bramctl_we  out  1  write strobe.
- o_wb_bramctl_en  out  1  port enable; equal to we.
- o_busy  out  1  high from accepted start until done/abort.
- o_done  out  1  one-cycle pulse at load completion.
- o_err  out  1  sticky: line address wrapped past 2^ADDR_W-1 during load.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, all outputs 0, lane=0, line=0, remaining=0.
- Clock i_clk, reset i_rst_n: one clock domain, asynchronous active-low reset.
- FSM states: IDLE, LOAD, FINISH.
- IDLE + i_start:
  - If i_num_words != 0: line<=i_start_addr, lane<=0, remaining<=i_num_words, o_err<=0, go to LOAD.
  - If i_num_words == 0: go to FINISH with no writes.
- o_busy=1 in LOAD and FINISH.
- i_start outside IDLE is ignored.
- o_s_ready = (state==LOAD) && (remaining!=0) && !i_abort. It is a combinational decode of registered state.
- Beat accepted at cycle N (valid&ready): at N+1 these outputs are registered:
  - we=en=1, addr=line, be = 4'hF << (4*lane), wdata = {LANES{i_s_data}}.
  - Otherwise at N+1: we=en=0, be=0; addr and wdata hold their last value.
- Write latency is exactly 1 cycle from acceptance.
- After each accepted beat:
  - remaining decrements.
  - If lane==LANES-1: lane<=0 and line<=line+1 (mod 2^ADDR_W).
  - Otherwise: lane<=lane+1.
- If line==2^ADDR_W-1 and lane==LANES-1 on an accepted beat that is not the last: line wraps to 0 and o_err<=1 (sticky until next accepted start).
- Last beat (remaining==1) accepted at N:
  - state<=FINISH.
  - At N+1: final write strobe and o_done=1 in the same cycle.
  - At N+2: state IDLE, o_busy=0.
- Zero-length load: i_start at N -> o_done=1 at N+1, IDLE at N+2, no write strobes.
- A partial final line writes only its filled lanes. Unwritten lanes are left untouched; no padding.
- i_abort in LOAD:
  - No beat is accepted that cycle.
  - Next cycle: state IDLE, o_busy=0, we/en/be=0, o_done stays 0, o_err holds.
  - i_abort in IDLE or FINISH has no effect.
- Stream stalls (i_s_valid=0) insert bubbles: no strobe, counters hold. There is no timeout.
- Back-to-back commands: a new i_start is accepted in the cycle after o_done (state IDLE).

Test Plan:
- Full line: start_addr=0x010, num_words=13, words 0x0000_0001..0x0000_000D with valid held high.
  - Expect 13 strobes, all addr=0x010.
  - be progresses 0x000_0000_0000_F, 0x..F0 up to 0xF_0000_0000_0000.
  - o_done coincides with the 13th strobe; o_busy falls one cycle later.
- Line crossing: start_addr=0x100, num_words=27.
  - Expect 13 writes at 0x100, 13 at 0x101, then 1 at 0x102 with be=0x000_0000_0000_F.
  - o_err=0.
- Stalls: toggle i_s_valid 1,0,0,1,... for num_words=5.
  - Expect exactly 5 strobes, each 1 cycle after its accepted beat.
  - Lane order 0..4, no duplicate or skipped lane.
- Wrap: start_addr=0x1FFF, num_words=14.
  - Expect 13 writes at 0x1FFF, 1 write at 0x0000.
  - o_err=1 after the wrap; it stays 1 after done and clears on the next start.
- Abort/ignore: start num_words=20, abort after 6 beats.
  - Expect 6 strobes, no o_done, o_busy=0 next cycle.
  - An i_start issued mid-load in a separate run is ignored (addr unchanged).
- Zero length and reset: num_words=0 gives o_done one cycle after start with no strobe.
  - Asserting i_rst_n=0 mid-load clears all outputs immediately (asynchronously).
  - After release, a fresh load starts at lane 0.

Source files
------------

// File: rtl/wb_stream_loader.sv
// Weight buffer write-side loader: packs a 32-bit valid/ready stream into
// 13-lane weight lines and issues one byte-enabled lane write per accepted word.
module wb_stream_loader #(
  parameter int LANES  = 13,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 17
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [ADDR_W-1:0]       i_start_addr,
  input  logic [CNT_W-1:0]        i_num_words,
  input  logic                    i_abort,
  input  logic [LANE_W-1:0]       i_s_data,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  output logic [LANES*LANE_W-1:0] o_wb_bramctl_wdata,
  output logic [ADDR_W-1:0]       o_wb_bramctl_addr,
  output logic [LANES*4-1:0]      o_wb_bramctl_be,
  output logic                    o_wb_bramctl_we,
  output logic                    o_wb_bramctl_en,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  // state  | meaning
  // IDLE   | waiting for a load command
  // LOAD   | accepting stream words, one lane write per word
  // FINISH | final write / done pulse cycle, back to IDLE next

  localparam int LANE_IW = $clog2(LANES);
  localparam int BE_W    = LANES * 4;
  localparam logic [BE_W-1:0]    BE_LANE0 = BE_W'(4'hF);
  localparam logic [LANE_IW-1:0] LAST_LANE = LANE_IW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                    state_q;
  logic [LANE_IW-1:0]        lane_q;
  logic [ADDR_W-1:0]         line_q;
  logic [CNT_W-1:0]          remaining_q;
  logic [LANES*LANE_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [BE_W-1:0]           be_q;
  logic                      we_q;
  logic                      done_q;
  logic                      err_q;

  logic                      beat;
  logic                      last_lane;
  logic                      last_beat;
  logic [BE_W-1:0]           be_d;
  logic [LANES*LANE_W-1:0]   wdata_d;
  logic [ADDR_W-1:0]         line_d;

  assign o_s_ready = (state_q == LOAD) && (remaining_q != '0) && !i_abort;
  assign beat      = i_s_valid && o_s_ready;
  assign last_lane = (lane_q == LAST_LANE);
  assign last_beat = (remaining_q == CNT_W'(1));
  assign be_d      = BE_LANE0 << {lane_q, 2'b00};
  assign wdata_d   = {LANES{i_s_data}};
  assign line_d    = line_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      line_q      <= '0;
      remaining_q <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      be_q   <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            err_q <= 1'b0;
            if (i_num_words != '0) begin
              line_q      <= i_start_addr;
              lane_q      <= '0;
              remaining_q <= i_num_words;
              state_q     <= LOAD;
            end else begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        LOAD: begin
          if (i_abort) begin
            state_q <= IDLE;
          end else if (beat) begin
            we_q        <= 1'b1;
            addr_q      <= line_q;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            remaining_q <= remaining_q - 1'b1;
            if (last_lane) begin
              lane_q <= '0;
              line_q <= line_d;
              // Wrapping the line address only matters if more words follow.
              if ((&line_q) && !last_beat) err_q <= 1'b1;
            end else begin
              lane_q <= lane_q + 1'b1;
            end
            if (last_beat) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_bramctl_wdata = wdata_q;
  assign o_wb_bramctl_addr  = addr_q;
  assign o_wb_bramctl_be    = be_q;
  assign o_wb_bramctl_we    = we_q;
  assign o_wb_bramctl_en    = we_q;
  assign o_busy             = (state_q != IDLE);
  assign o_done             = done_q;
  assign o_err              = err_q;

endmodule

// File: tb/tb_wb_stream_loader.sv
// Directed bench for wb_stream_loader with a write scoreboard fed from an
// independent line/lane model of each load.
module tb_wb_stream_loader;

  localparam int LANES  = 13;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 13;
  localparam int CNT_W  = 17;

  logic                    clk;
  logic                    rst_n;
  logic                    i_start;
  logic [ADDR_W-1:0]       i_start_addr;
  logic [CNT_W-1:0]        i_num_words;
  logic                    i_abort;
  logic [LANE_W-1:0]       i_s_data;
  logic                    i_s_valid;
  logic                    o_s_ready;
  logic [LANES*LANE_W-1:0] o_wdata;
  logic [ADDR_W-1:0]       o_addr;
  logic [LANES*4-1:0]      o_be;
  logic                    o_we;
  logic                    o_en;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_err;

  wb_stream_loader #(
    .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_start            (i_start),
    .i_start_addr       (i_start_addr),
    .i_num_words        (i_num_words),
    .i_abort            (i_abort),
    .i_s_data           (i_s_data),
    .i_s_valid          (i_s_valid),
    .o_s_ready          (o_s_ready),
    .o_wb_bramctl_wdata (o_wdata),
    .o_wb_bramctl_addr  (o_addr),
    .o_wb_bramctl_be    (o_be),
    .o_wb_bramctl_we    (o_we),
    .o_wb_bramctl_en    (o_en),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_err              (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [ADDR_W-1:0]       addr;
    logic [LANES*4-1:0]      be;
    logic [LANES*LANE_W-1:0] wdata;
    int                      cyc;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;

  int checks = 0;
  int failures = 0;

  int m_base;
  int m_k;
  int nacc;

  task automatic chk(input string tag, input logic [LANES*LANE_W-1:0] obs,
                     input logic [LANES*LANE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [LANE_W-1:0] d);
    wr_t e;
    int lane;
    logic [LANES*4-1:0] one_lane;
    lane       = m_k % LANES;
    one_lane   = '0;
    one_lane[3:0] = 4'hF;
    e.addr     = ADDR_W'((m_base + m_k / LANES) % (1 << ADDR_W));
    e.be       = one_lane << (4 * lane);
    e.wdata    = {LANES{d}};
    e.cyc      = cyc + 1;
    sb.push_back(e);
    m_k++;
  endtask

  // One clock of stimulus, driven at the falling edge; outputs sampled after
  // this call reflect the previous rising edge.
  task automatic step(input logic st, input logic v, input logic [LANE_W-1:0] d,
                      input logic ab);
    @(negedge clk);
    i_start   = st;
    i_s_valid = v;
    i_s_data  = d;
    i_abort   = ab;
    #1;
    if (v && o_s_ready) begin
      push_exp(d);
      nacc++;
    end
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] a, input int n);
    i_start_addr = a;
    i_num_words  = CNT_W'(n);
    m_base = int'(a);
    m_k    = 0;
    nacc   = 0;
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic finish_check(input string tag, input logic exp_err);
    step(1'b0, 1'b0, '0, 1'b0);
    chk({tag, "_done"}, o_done, 1'b1);
    chk({tag, "_last_we"}, o_we, 1'b1);
    chk({tag, "_busy_at_done"}, o_busy, 1'b1);
    chk({tag, "_err"}, o_err, exp_err);
    step(1'b0, 1'b0, '0, 1'b0);
    chk({tag, "_busy_after"}, o_busy, 1'b0);
    chk({tag, "_done_pulse"}, o_done, 1'b0);
    chk({tag, "_err_hold"}, o_err, exp_err);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("en_eq_we", o_en, o_we);
      if (o_we === 1'b1) begin
        chk("write_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("wr_addr", o_addr, mon_e.addr);
          chk("wr_be", o_be, mon_e.be);
          chk("wr_wdata", o_wdata, mon_e.wdata);
          chk("wr_latency", cyc, mon_e.cyc);
        end
      end else begin
        chk("be_idle", o_be, '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_start_addr = '0;
    i_num_words = '0;
    i_abort = 1'b0;
    i_s_data = '0;
    i_s_valid = 1'b0;
    m_base = 0;
    m_k = 0;
    nacc = 0;

    #12;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_we", o_we, 1'b0);
    chk("rst_ready", o_s_ready, 1'b0);
    chk("rst_addr", o_addr, '0);
    chk("rst_wdata", o_wdata, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full line
    start_load(13'h010, 13);
    for (int i = 1; i <= 13; i++) begin
      step(1'b0, 1'b1, LANE_W'(i), 1'b0);
      if (i == 1) chk("t1_busy", o_busy, 1'b1);
    end
    chk("t1_accepted", nacc, 13);
    finish_check("t1", 1'b0);

    // Line crossing
    start_load(13'h100, 27);
    for (int i = 0; i < 27; i++) step(1'b0, 1'b1, 32'hA000_0000 + LANE_W'(i), 1'b0);
    chk("t2_accepted", nacc, 27);
    finish_check("t2", 1'b0);

    // Stalls
    start_load(13'h050, 5);
    for (int i = 0; i < 40 && nacc < 5; i++)
      step(1'b0, (i % 3) == 0, 32'hB000_0000 + LANE_W'(i), 1'b0);
    chk("t3_accepted", nacc, 5);
    finish_check("t3", 1'b0);

    // Address wrap
    start_load(13'h1FFF, 14);
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 1'b1, 32'hC000_0000 + LANE_W'(i), 1'b0);
      if (i == 13) chk("t4_err_before_wrap", o_err, 1'b0);
      if (i == 14) chk("t4_err_after_wrap", o_err, 1'b1);
    end
    finish_check("t4", 1'b1);

    // Abort after 6 beats; the new start also clears the sticky error
    start_load(13'h200, 20);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, 32'hD000_0000 + LANE_W'(i), 1'b0);
      if (i == 1) chk("t5_err_cleared", o_err, 1'b0);
    end
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("t5_ready_abort", o_s_ready, 1'b0);
    chk("t5_busy_abort", o_busy, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t5_busy_after", o_busy, 1'b0);
    chk("t5_we_after", o_we, 1'b0);
    chk("t5_done_after", o_done, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t5_no_done", o_done, 1'b0);
    chk("t5_accepted", nacc, 6);

    // Start issued mid-load is ignored
    start_load(13'h020, 3);
    step(1'b0, 1'b1, 32'hE000_0001, 1'b0);
    i_start_addr = 13'h0555;
    i_num_words  = 17'd9;
    step(1'b1, 1'b1, 32'hE000_0002, 1'b0);
    step(1'b0, 1'b1, 32'hE000_0003, 1'b0);
    chk("t5b_accepted", nacc, 3);
    finish_check("t5b", 1'b0);

    // Zero-length load
    start_load(13'h060, 0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t6_done", o_done, 1'b1);
    chk("t6_busy", o_busy, 1'b1);
    chk("t6_no_we", o_we, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t6_busy_after", o_busy, 1'b0);
    chk("t6_done_pulse", o_done, 1'b0);
    chk("t6_accepted", nacc, 0);

    // Asynchronous reset mid-load
    start_load(13'h030, 10);
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 32'hF000_0000 + LANE_W'(i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t7_busy_pre", o_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", o_busy, 1'b0);
    chk("t7_rst_we", o_we, 1'b0);
    chk("t7_rst_en", o_en, 1'b0);
    chk("t7_rst_be", o_be, '0);
    chk("t7_rst_addr", o_addr, '0);
    chk("t7_rst_wdata", o_wdata, '0);
    chk("t7_rst_ready", o_s_ready, 1'b0);
    chk("t7_sb_empty", sb.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_load(13'h040, 2);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0);
    step(1'b0, 1'b1, 32'h9ABC_DEF0, 1'b0);
    chk("t7_accepted", nacc, 2);
    finish_check("t7", 1'b0);

    step(1'b0, 1'b0, '0, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
